// File: rtl/spi_host_if.sv
// spi_host_if: byte-stream and SPI pin bundle for spi_host.
//   tx_data/tx_last/tx_valid/tx_ready : byte stream into the controller
//   rx_data/rx_valid                  : byte shifted in from MISO, one-cycle strobe
//   busy                              : frame in progress
//   spi_cs/spi_sclk/spi_mosi/spi_miso : SPI mode-0 pins
// Modports: master = the controller itself, slave = the byte-stream client / SPI target side.
interface spi_host_if;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_cs;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  modport master (
    input  tx_data, tx_last, tx_valid, spi_miso,
    output tx_ready, rx_data, rx_valid, busy, spi_cs, spi_sclk, spi_mosi
  );

  modport slave (
    output tx_data, tx_last, tx_valid, spi_miso,
    input  tx_ready, rx_data, rx_valid, busy, spi_cs, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/spi_host.sv
// spi_host: SPI mode-0 initiator fed by a valid/ready byte stream.
//   clk_i  : system clock, rising edge
//   rst_ni : synchronous active-low reset
//   bus    : spi_host_if.master (byte stream in, rx byte out, busy, SPI pins)
// Frames are one or more bytes, MSB first; CS stays low between bytes until
// a byte tagged last completes, then a HOLD and a GAP phase of CLK_DIV cycles.
// CLK_DIV is the sclk half-period in clk_i cycles (2..255).
module spi_host #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  spi_host_if.master bus
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] PH_LOAD = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD, GAP} state_t;

  state_t        state;
  logic [CW-1:0] ph_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    tx_sh;     // bit 7 goes straight to mosi; only the remaining 7 are kept
  logic [6:0]    rx_sh;     // final bit is merged directly into rx_data
  logic          last;
  logic          cs_q;
  logic          sclk_q;
  logic          mosi_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          accept;

  // A last byte never raises ready in NEXT; the FSM moves straight to HOLD.
  assign bus.tx_ready = (state == IDLE) || (state == NEXT && !last);
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign bus.busy     = (state != IDLE);
  assign bus.spi_cs   = cs_q;
  assign bus.spi_sclk = sclk_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      ph_cnt     <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      last       <= 1'b0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        IDLE, NEXT: begin
          if (state == NEXT && last) begin
            state  <= HOLD;
            ph_cnt <= PH_LOAD;
          end else if (accept) begin
            tx_sh   <= bus.tx_data[6:0];
            mosi_q  <= bus.tx_data[7];
            last    <= bus.tx_last;
            bit_cnt <= '0;
            cs_q    <= 1'b0;
            ph_cnt  <= PH_LOAD;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (ph_cnt == '0) begin
            sclk_q <= 1'b1;
            ph_cnt <= PH_LOAD;
            state  <= SHIFT;
          end else begin
            ph_cnt <= ph_cnt - CW'(1);
          end
        end
        SHIFT: begin
          if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - CW'(1);
          end else if (sclk_q) begin
            // End of high phase: sclk falls, MISO sampled, MOSI advances.
            sclk_q <= 1'b0;
            ph_cnt <= PH_LOAD;
            rx_sh  <= {rx_sh[5:0], bus.spi_miso};
            if (bit_cnt == 3'd7) begin
              rx_data_q  <= {rx_sh, bus.spi_miso};
              rx_valid_q <= 1'b1;
              mosi_q     <= 1'b0;
              state      <= NEXT;
            end else begin
              mosi_q  <= tx_sh[6];
              tx_sh   <= {tx_sh[5:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            sclk_q <= 1'b1;
            ph_cnt <= PH_LOAD;
          end
        end
        HOLD: begin
          mosi_q <= 1'b0;
          if (ph_cnt == '0) begin
            cs_q   <= 1'b1;
            ph_cnt <= PH_LOAD;
            state  <= GAP;
          end else begin
            ph_cnt <= ph_cnt - CW'(1);
          end
        end
        GAP: begin
          if (ph_cnt == '0) begin
            state <= IDLE;
          end else begin
            ph_cnt <= ph_cnt - CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          cs_q   <= 1'b1;
          sclk_q <= 1'b0;
          mosi_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: scoreboard bench for spi_host, with a CLK_DIV=2 and a CLK_DIV=4
// instance sharing one stimulus path selected by sel, and a mode-0 MISO target model.
module tb_spi_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  int unsigned d_cur = 2;
  logic [7:0]  tx_data = '0;
  logic        tx_last = 1'b0;
  logic        tx_valid = 1'b0;
  logic        miso = 1'b0;

  spi_host_if bus2();
  spi_host_if bus4();

  spi_host #(.CLK_DIV(2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2.master));
  spi_host #(.CLK_DIV(4)) dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(bus4.master));

  assign bus2.tx_data  = tx_data;
  assign bus2.tx_last  = tx_last;
  assign bus2.tx_valid = tx_valid & ~sel;
  assign bus2.spi_miso = miso;
  assign bus4.tx_data  = tx_data;
  assign bus4.tx_last  = tx_last;
  assign bus4.tx_valid = tx_valid & sel;
  assign bus4.spi_miso = miso;

  logic       cs, sclk, mosi, ready, busy, rxv;
  logic [7:0] rxd;
  always_comb begin
    cs    = sel ? bus4.spi_cs   : bus2.spi_cs;
    sclk  = sel ? bus4.spi_sclk : bus2.spi_sclk;
    mosi  = sel ? bus4.spi_mosi : bus2.spi_mosi;
    ready = sel ? bus4.tx_ready : bus2.tx_ready;
    busy  = sel ? bus4.busy     : bus2.busy;
    rxv   = sel ? bus4.rx_valid : bus2.rx_valid;
    rxd   = sel ? bus4.rx_data  : bus2.rx_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // Scoreboard queues
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] miso_q[$];
  int         acc_q[$];
  int         last_acc = 0;

  // Monitor and MISO target model, all sampled on the falling clk edge
  logic       prev_sclk = 1'b0, prev_cs = 1'b1, prev_mosi = 1'b0;
  int         high_run = 0, mosi_cnt = 0, rise_cnt = 0, mosi_glitch = 0;
  int         cs_fall_edge = 0, cs_rise_edge = 0, cs_rise_cnt = 0;
  int         last_rx_edge = 0, prev_rx_edge = 0;
  logic [7:0] mosi_sh = '0;
  logic [7:0] m_sh = '0;
  int         m_idx = 0;
  logic       m_loaded = 1'b0;

  always @(negedge clk) begin
    if (sclk && !prev_sclk) begin
      rise_cnt++;
      high_run = 1;
      mosi_sh = {mosi_sh[6:0], mosi};
      mosi_cnt++;
      if (mosi_cnt == 8) begin
        mosi_cnt = 0;
        if (exp_tx.size() == 0) chk("mosi_unexpected", 1, 0);
        else chk("mosi_byte", mosi_sh, exp_tx.pop_front());
      end
    end else if (sclk && prev_sclk) begin
      high_run++;
      if (mosi !== prev_mosi) mosi_glitch++;
    end
    if (!sclk && prev_sclk) begin
      chk("sclk_high_len", high_run, d_cur);
      m_idx++;
      if (m_idx == 8) begin
        m_idx = 0;
        m_loaded = 1'b0;
      end else begin
        miso = m_sh[7 - m_idx];
      end
    end
    if (cs) begin
      m_idx = 0;
      m_loaded = 1'b0;
      mosi_cnt = 0;
    end else if (!m_loaded && miso_q.size() > 0) begin
      m_sh = miso_q.pop_front();
      m_loaded = 1'b1;
      miso = m_sh[7];
    end
    if (!cs && prev_cs) cs_fall_edge = edges;
    if (cs && !prev_cs) begin
      cs_rise_edge = edges;
      cs_rise_cnt++;
    end
    if (rxv) begin
      prev_rx_edge = last_rx_edge;
      last_rx_edge = edges;
      if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
      else chk("rx_data", rxd, exp_rx.pop_front());
      if (acc_q.size() > 0) chk("rx_valid_cycle", edges - acc_q.pop_front() + 1, 16 * d_cur + 1);
    end
    prev_sclk = sclk;
    prev_cs   = cs;
    prev_mosi = mosi;
  end

  // Present a byte and hold valid until accepted; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] d, input logic l, input logic [7:0] r);
    int n;
    n = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("accept_timeout", 0, 1);
      tx_valid = 1'b0;
    end else begin
      exp_tx.push_back(d);
      exp_rx.push_back(r);
      miso_q.push_back(r);
      acc_q.push_back(edges + 1);
      last_acc = edges + 1;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
    chk("idle_cycle", edges - last_acc + 1, 18 * d_cur + 2);
  endtask

  initial begin
    int a1, a2, rc0, cr0, n, bad, hi;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rx_data", rxd, 0);
    chk("rst_rx_valid", rxv, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready, 1);

    // Single byte, CLK_DIV=2
    send(8'hA5, 1'b1, 8'h3C);
    tx_valid = 1'b0;
    wait_idle();
    chk("single_cs_fall", cs_fall_edge - last_acc + 1, 1);
    chk("single_cs_rise", cs_rise_edge - last_acc + 1, 36);

    // Back-to-back two-byte frame, valid held
    rc0 = rise_cnt;
    cr0 = cs_rise_cnt;
    send(8'h12, 1'b0, 8'hE1);
    a1 = last_acc;
    send(8'h34, 1'b1, 8'h6B);
    a2 = last_acc;
    tx_valid = 1'b0;
    chk("b2b_accept", a2 - a1, 33);
    wait_idle();
    chk("b2b_rx_spacing", last_rx_edge - prev_rx_edge, 33);
    chk("b2b_rises", rise_cnt - rc0, 16);
    chk("b2b_cs_rises", cs_rise_cnt - cr0, 1);

    // Stall in NEXT for 10 cycles
    send(8'h12, 1'b0, 8'h5A);
    tx_valid = 1'b0;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_next", ready, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (cs !== 1'b0 || sclk !== 1'b0 || ready !== 1'b1 || busy !== 1'b1) bad++;
    end
    chk("stall_hold", bad, 0);
    send(8'h34, 1'b1, 8'hA7);
    tx_valid = 1'b0;
    wait_idle();

    // Reset mid-byte at cycle 10
    send(8'hA5, 1'b1, 8'h3C);
    tx_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_tx.delete();
    exp_rx.delete();
    miso_q.delete();
    acc_q.delete();
    @(negedge clk);
    chk("midrst_cs", cs, 1);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_mosi", mosi, 0);
    chk("midrst_rx_data", rxd, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", ready, 1);
    send(8'hFF, 1'b1, 8'h81);
    tx_valid = 1'b0;
    wait_idle();

    // CLK_DIV=4, byte 0x80
    sel = 1'b1;
    d_cur = 4;
    @(negedge clk);
    send(8'h80, 1'b1, 8'hC3);
    tx_valid = 1'b0;
    n = 0;
    while (!(prev_sclk == 1'b0 && rise_cnt > 0 && !sclk && n > 4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    // now past the first sclk falling edge; MOSI must stay low from here on
    hi = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
      if (mosi) hi++;
    end
    chk("div4_mosi_low_after_msb", hi, 0);
    wait_idle();

    // Valid held while busy: no accept until IDLE
    sel = 1'b0;
    d_cur = 2;
    @(negedge clk);
    send(8'hC6, 1'b1, 8'h29);
    a1 = last_acc;
    send(8'h55, 1'b1, 8'h96);
    a2 = last_acc;
    tx_valid = 1'b0;
    chk("busy_no_accept", a2 - a1, 38);
    wait_idle();

    repeat (4) @(negedge clk);
    chk("sb_tx_empty", exp_tx.size(), 0);
    chk("sb_rx_empty", exp_rx.size(), 0);
    chk("mosi_stable_high", mosi_glitch, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
